// File: rtl/fetch_bundle_gen_if.sv
// Interface bundling the I-cache port, redirect input, instruction-buffer side
// and FSM debug view of fetch_bundle_gen.
//
// Handshake: icache_req_o/icache_gnt_i transfer one line request on a cycle
// where both are 1 (gnt is only meaningful while req is 1). Exactly one
// icache_rvld_i pulse returns per granted request, in request order.
// bundle_vld_o is nonzero only in the cycle a bundle is transferred, which
// requires buf_full_i=0 in that same cycle.
interface fetch_bundle_gen_if #(
  parameter int PC_W = 64
);
  logic            flush_i;
  logic [PC_W-1:0] redirect_pc_i;
  logic            icache_req_o;
  logic [PC_W-1:0] icache_addr_o;
  logic            icache_gnt_i;
  logic            icache_rvld_i;
  logic [255:0]    icache_line_i;
  logic            buf_full_i;
  logic [255:0]    bundle_inst_o;
  logic [7:0]      bundle_vld_o;
  logic [PC_W-1:0] bundle_pc_o;
  logic [1:0]      dbg_state_o;

  // Fetch unit side.
  modport master (
    input  flush_i, redirect_pc_i, icache_gnt_i, icache_rvld_i, icache_line_i, buf_full_i,
    output icache_req_o, icache_addr_o, bundle_inst_o, bundle_vld_o, bundle_pc_o, dbg_state_o
  );

  // Environment side (I-cache, instruction buffer, redirect source).
  modport slave (
    output flush_i, redirect_pc_i, icache_gnt_i, icache_rvld_i, icache_line_i, buf_full_i,
    input  icache_req_o, icache_addr_o, bundle_inst_o, bundle_vld_o, bundle_pc_o, dbg_state_o
  );
endinterface

// File: rtl/fetch_bundle_gen.sv
// Fetch bundle generator: requests one aligned 32-byte line per fetch, masks
// the slots before the fetch offset and emits an 8-slot bundle to the
// instruction buffer. Redirects abandon the current fetch; responses to
// requests issued before a redirect are counted and discarded in order.
// Optional feature macro: FETCH_BR_CUT_EN (cut the bundle after the first
// branch/jump slot and resume fetch at its fall-through address).
module fetch_bundle_gen #(
  parameter int              PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input logic                clock,
  input logic                reset_n,
  fetch_bundle_gen_if.master bus
);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_EMIT = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [PC_W-1:2] r_pc, w_pc_nxt;        // word address; byte bits [1:0] are always 0
  logic [255:0]    r_line;
  logic [7:0]      r_mask;
  logic [1:0]      r_drop_cnt, w_drop_nxt; // stale responses still to be discarded
  logic            w_req, w_emit;
  logic            w_rsp_live, w_rsp_stale, w_capture;
  logic [7:0]      w_emit_mask;
  logic [PC_W-1:2] w_pc_seq, w_pc_adv;
  logic            w_unused;

  assign w_unused    = ^bus.redirect_pc_i[1:0];
  assign w_rsp_stale = bus.icache_rvld_i && (r_drop_cnt != 2'd0);
  assign w_rsp_live  = bus.icache_rvld_i && (r_drop_cnt == 2'd0) && (r_state == ST_WAIT);
  assign w_capture   = w_rsp_live && !bus.flush_i;
  assign w_pc_seq    = {r_pc[PC_W-1:5] + (PC_W-5)'(1), 3'b000};

`ifdef FETCH_BR_CUT_EN
  logic       w_cut_hit;
  logic [2:0] w_cut_slot;
  logic [7:0] w_keep;

  function automatic logic is_branch(input logic [5:0] op);
    return (op == 6'h1A) || (op[5:4] == 2'b11);
  endfunction

  // Find the lowest enabled branch slot; trim the bundle after it and resume at its fall-through.
  always_comb begin
    w_cut_hit   = 1'b0;
    w_cut_slot  = 3'd0;
    w_keep      = 8'hFF;
    w_emit_mask = r_mask;
    w_pc_adv    = w_pc_seq;
    for (int k = 7; k >= 0; k--) begin
      if (r_mask[k] && is_branch(r_line[32*k+26 +: 6])) begin
        w_cut_hit  = 1'b1;
        w_cut_slot = 3'(k);
      end
    end
    if (w_cut_hit) begin
      w_keep      = (8'd2 << w_cut_slot) - 8'd1;
      w_emit_mask = r_mask & w_keep;
      w_pc_adv    = {r_pc[PC_W-1:5], 3'b000} + (PC_W-2)'({1'b0, w_cut_slot} + 4'd1);
    end
  end
`else
  assign w_emit_mask = r_mask;
  assign w_pc_adv    = w_pc_seq;
`endif

  // Next-state and handshake outputs; a redirect overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_emit      = 1'b0;
    case (r_state)
      ST_REQ: begin
        w_req = 1'b1;
        if (bus.icache_gnt_i) w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (w_rsp_live) w_state_nxt = ST_EMIT;
      end
      ST_EMIT: begin
        if (!bus.buf_full_i) begin
          w_emit      = 1'b1;
          w_state_nxt = ST_REQ;
        end
      end
      default: w_state_nxt = ST_REQ;
    endcase
    if (bus.flush_i) begin
      w_state_nxt = ST_REQ;
      w_emit      = 1'b0;
    end
  end

  // Stale-response bookkeeping: retire one per stale rvld, add one when a redirect orphans a live request.
  always_comb begin
    w_drop_nxt = r_drop_cnt;
    if (w_rsp_stale) w_drop_nxt = w_drop_nxt - 2'd1;
    if (bus.flush_i && (((r_state == ST_REQ) && bus.icache_gnt_i) ||
                        ((r_state == ST_WAIT) && !w_rsp_live)))
      w_drop_nxt = w_drop_nxt + 2'd1;
  end

  // Fetch PC selection: redirect first, otherwise advance when a bundle leaves.
  always_comb begin
    w_pc_nxt = r_pc;
    if (bus.flush_i)  w_pc_nxt = bus.redirect_pc_i[PC_W-1:2];
    else if (w_emit)  w_pc_nxt = w_pc_adv;
  end

  // State, PC, stale count and captured line registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_REQ;
      r_pc       <= RESET_PC[PC_W-1:2];
      r_drop_cnt <= 2'd0;
      r_line     <= '0;
      r_mask     <= 8'h00;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_drop_cnt <= w_drop_nxt;
      if (w_capture) begin
        r_line <= bus.icache_line_i;
        r_mask <= 8'hFF << r_pc[4:2];
      end
    end
  end

  assign bus.icache_req_o  = w_req & reset_n;
  assign bus.icache_addr_o = {r_pc[PC_W-1:5], 5'b00000};
  assign bus.bundle_inst_o = r_line;
  assign bus.bundle_vld_o  = w_emit ? w_emit_mask : 8'h00;
  assign bus.bundle_pc_o   = {r_pc[PC_W-1:5], 5'b00000};
  assign bus.dbg_state_o   = r_state;

endmodule

// File: tb/tb_fetch_bundle_gen.sv
// Testbench for fetch_bundle_gen: directed hand sequences, a table of fetch
// vectors, and a randomized run against a transaction-level reference model.
module tb_fetch_bundle_gen;
`ifdef FETCH_BR_CUT_EN
  localparam bit BR_EN = 1'b1;
`else
  localparam bit BR_EN = 1'b0;
`endif
  localparam int W = 256;

  logic clock = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  fetch_bundle_gen_if #(.PC_W(64)) bus ();
  fetch_bundle_gen #(.PC_W(64), .RESET_PC(64'h0)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  typedef struct {
    logic [W-1:0] inst;
    logic [7:0]   mask;
    logic [63:0]  pc;
    logic [63:0]  next_pc;
  } bund_t;

  typedef struct {
    logic [63:0] pc;
    logic [7:0]  br_map;
    logic [5:0]  br_op;
    logic [63:0] exp_addr;
    logic [7:0]  exp_vld;
    logic [63:0] exp_next;
    logic [7:0]  exp_vld2;
  } vec_t;

  bund_t        exp_q[$];
  vec_t         vecs[7];
  logic [W-1:0] cq_data[$];
  int           cq_due[$];
  bit           out_stale[$];

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] make_line(input logic [7:0] br_map, input logic [5:0] br_op,
                                              input logic [25:0] seed);
    logic [W-1:0] l;
    for (int k = 0; k < 8; k++) begin
      if (br_map[k]) l[32*k +: 32] = {br_op, seed ^ 26'(k)};
      else           l[32*k +: 32] = {6'h11, seed ^ 26'(k * 5)};
    end
    return l;
  endfunction

  function automatic logic [W-1:0] rand_line();
    logic [W-1:0] l;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = $urandom;
    return l;
  endfunction

  // Reference: bundle produced by fetching at pc, from the slot/branch rules.
  function automatic bund_t model_bundle(input logic [63:0] pc, input logic [W-1:0] line);
    bund_t       b;
    logic [63:0] base;
    int          off;
    bit          cut;
    logic [5:0]  op;
    base      = pc - (pc % 64'd32);
    off       = int'((pc % 64'd32) / 64'd4);
    b.inst    = line;
    b.mask    = 8'h00;
    b.pc      = base;
    b.next_pc = base + 64'd32;
    cut       = 1'b0;
    for (int k = off; k < 8; k++) begin
      if (!cut) begin
        b.mask[k] = 1'b1;
        op = line[32*k+26 +: 6];
        if (BR_EN && (op == 6'h1A || op >= 6'h30)) begin
          cut       = 1'b1;
          b.next_pc = base + 64'(4 * (k + 1));
        end
      end
    end
    return b;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic run_vec(input int i, input vec_t v);
    logic [W-1:0] l1, l2;
    l1 = make_line(v.br_map, v.br_op, 26'(i * 1000 + 7));
    l2 = make_line(8'h00, 6'h00, 26'(i * 1000 + 99));
    bus.flush_i = 1'b1; bus.redirect_pc_i = v.pc;
    #1 chk($sformatf("v%0d_flush_vld", i), W'(bus.bundle_vld_o), W'(8'h00));
    tick();
    bus.flush_i = 1'b0;
    #1 chk($sformatf("v%0d_req", i), W'(bus.icache_req_o), W'(1'b1));
    chk($sformatf("v%0d_addr", i), W'(bus.icache_addr_o), W'(v.exp_addr));
    bus.icache_gnt_i = 1'b1;
    tick();
    bus.icache_gnt_i = 1'b0; bus.icache_rvld_i = 1'b1; bus.icache_line_i = l1;
    #1 chk($sformatf("v%0d_no_req_wait", i), W'(bus.icache_req_o), W'(1'b0));
    tick();
    bus.icache_rvld_i = 1'b0;
    #1 chk($sformatf("v%0d_vld", i), W'(bus.bundle_vld_o), W'(v.exp_vld));
    chk($sformatf("v%0d_inst", i), bus.bundle_inst_o, l1);
    chk($sformatf("v%0d_bpc", i), W'(bus.bundle_pc_o), W'(v.exp_addr));
    tick();
    #1 chk($sformatf("v%0d_next_addr", i), W'(bus.icache_addr_o), W'(v.exp_next));
    chk($sformatf("v%0d_next_req", i), W'(bus.icache_req_o), W'(1'b1));
    bus.icache_gnt_i = 1'b1;
    tick();
    bus.icache_gnt_i = 1'b0; bus.icache_rvld_i = 1'b1; bus.icache_line_i = l2;
    tick();
    bus.icache_rvld_i = 1'b0;
    #1 chk($sformatf("v%0d_vld2", i), W'(bus.bundle_vld_o), W'(v.exp_vld2));
    chk($sformatf("v%0d_bpc2", i), W'(bus.bundle_pc_o), W'(v.exp_next));
    tick();
  endtask

  // ---------------- main ----------------
  initial begin
    logic [W-1:0] la, lb, lc;
    logic [7:0]   exp_vld;
    bit           exp_req, live_out, emitting, stale;

    vecs[0] = '{64'h1008, 8'h00, 6'h00, 64'h1000, 8'hFC, 64'h1020, 8'hFF};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFE0, 8'h00, 6'h00, 64'hFFFF_FFFF_FFFF_FFE0, 8'hFF, 64'h0, 8'hFF};
    vecs[2] = '{64'h100, 8'h04, 6'h39, 64'h100, BR_EN ? 8'h07 : 8'hFF,
                BR_EN ? 64'h100 : 64'h120, BR_EN ? 8'hF8 : 8'hFF};
    vecs[3] = '{64'h11C, 8'h00, 6'h00, 64'h100, 8'h80, 64'h120, 8'hFF};
    vecs[4] = '{64'h20F, 8'h00, 6'h00, 64'h200, 8'hF8, 64'h220, 8'hFF};
    vecs[5] = '{64'hA4, 8'h02, 6'h1A, 64'hA0, BR_EN ? 8'h02 : 8'hFE,
                BR_EN ? 64'hA0 : 64'hC0, BR_EN ? 8'hFC : 8'hFF};
    vecs[6] = '{64'h308, 8'h81, 6'h30, 64'h300, 8'hFC, 64'h320, 8'hFF};

    // reset block
    reset_n = 1'b0;
    bus.flush_i = 1'b0; bus.redirect_pc_i = '0; bus.icache_gnt_i = 1'b0;
    bus.icache_rvld_i = 1'b0; bus.icache_line_i = '0; bus.buf_full_i = 1'b0;
    repeat (3) tick();
    #1 chk("rst_req", W'(bus.icache_req_o), W'(1'b0));
    chk("rst_vld", W'(bus.bundle_vld_o), W'(8'h00));
    chk("rst_inst", bus.bundle_inst_o, '0);
    chk("rst_bpc", W'(bus.bundle_pc_o), W'(64'h0));
    tick();

    // first fetch after reset, 1-cycle cache latency
    la = make_line(8'h00, 6'h00, 26'h123);
    reset_n = 1'b1;
    #1 chk("t1_req", W'(bus.icache_req_o), W'(1'b1));
    chk("t1_addr", W'(bus.icache_addr_o), W'(64'h0));
    bus.icache_gnt_i = 1'b1;
    tick();
    bus.icache_gnt_i = 1'b0; bus.icache_rvld_i = 1'b1; bus.icache_line_i = la;
    #1 chk("t1_wait_req", W'(bus.icache_req_o), W'(1'b0));
    tick();
    bus.icache_rvld_i = 1'b0;
    #1 chk("t1_vld", W'(bus.bundle_vld_o), W'(8'hFF));
    chk("t1_inst", bus.bundle_inst_o, la);
    chk("t1_bpc", W'(bus.bundle_pc_o), W'(64'h0));
    tick();
    #1 chk("t1_next_addr", W'(bus.icache_addr_o), W'(64'h20));

    // buffer full holds the bundle for 5 cycles
    la = make_line(8'h00, 6'h00, 26'h3A5);
    bus.flush_i = 1'b1; bus.redirect_pc_i = 64'h500;
    tick();
    bus.flush_i = 1'b0; bus.icache_gnt_i = 1'b1;
    #1 chk("t3_addr", W'(bus.icache_addr_o), W'(64'h500));
    tick();
    bus.icache_gnt_i = 1'b0; bus.icache_rvld_i = 1'b1; bus.icache_line_i = la;
    tick();
    bus.icache_rvld_i = 1'b0; bus.icache_line_i = '1; bus.buf_full_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1 chk($sformatf("t3_full_vld%0d", i), W'(bus.bundle_vld_o), W'(8'h00));
      chk($sformatf("t3_full_inst%0d", i), bus.bundle_inst_o, la);
      chk($sformatf("t3_full_req%0d", i), W'(bus.icache_req_o), W'(1'b0));
      tick();
    end
    bus.buf_full_i = 1'b0;
    #1 chk("t3_vld", W'(bus.bundle_vld_o), W'(8'hFF));
    chk("t3_inst", bus.bundle_inst_o, la);
    tick();
    #1 chk("t3_next_addr", W'(bus.icache_addr_o), W'(64'h520));

    // flush in WAIT before the response: stale line must be dropped
    la = make_line(8'h00, 6'h00, 26'h0BAD);
    lb = make_line(8'h00, 6'h00, 26'h0040);
    bus.icache_gnt_i = 1'b1;
    tick();
    bus.icache_gnt_i = 1'b0; bus.flush_i = 1'b1; bus.redirect_pc_i = 64'h40;
    #1 chk("t4_flush_vld", W'(bus.bundle_vld_o), W'(8'h00));
    tick();
    bus.flush_i = 1'b0;
    #1 chk("t4_req", W'(bus.icache_req_o), W'(1'b1));
    chk("t4_addr", W'(bus.icache_addr_o), W'(64'h40));
    bus.icache_gnt_i = 1'b1;
    tick();
    bus.icache_gnt_i = 1'b0; bus.icache_rvld_i = 1'b1; bus.icache_line_i = la;
    tick();
    bus.icache_line_i = lb;
    #1 chk("t4_stale_not_emitted", W'(bus.bundle_vld_o), W'(8'h00));
    tick();
    bus.icache_rvld_i = 1'b0;
    #1 chk("t4_vld", W'(bus.bundle_vld_o), W'(8'hFF));
    chk("t4_inst", bus.bundle_inst_o, lb);
    chk("t4_bpc", W'(bus.bundle_pc_o), W'(64'h40));
    tick();

    // flush in the same cycle as the response: response discarded, no extra drop
    la = make_line(8'h00, 6'h00, 26'h0777);
    lb = make_line(8'h00, 6'h00, 26'h0600);
    bus.icache_gnt_i = 1'b1;
    tick();
    bus.icache_gnt_i = 1'b0; bus.icache_rvld_i = 1'b1; bus.icache_line_i = la;
    bus.flush_i = 1'b1; bus.redirect_pc_i = 64'h600;
    #1 chk("t5_flush_vld", W'(bus.bundle_vld_o), W'(8'h00));
    tick();
    bus.icache_rvld_i = 1'b0; bus.flush_i = 1'b0;
    #1 chk("t5_addr", W'(bus.icache_addr_o), W'(64'h600));
    bus.icache_gnt_i = 1'b1;
    tick();
    bus.icache_gnt_i = 1'b0; bus.icache_rvld_i = 1'b1; bus.icache_line_i = lb;
    tick();
    bus.icache_rvld_i = 1'b0;
    #1 chk("t5_vld", W'(bus.bundle_vld_o), W'(8'hFF));
    chk("t5_inst", bus.bundle_inst_o, lb);
    tick();

    // flush in REQ together with a grant: granted line is stale
    la = make_line(8'h00, 6'h00, 26'h0AAA);
    lc = make_line(8'h00, 6'h00, 26'h0700);
    bus.icache_gnt_i = 1'b1; bus.flush_i = 1'b1; bus.redirect_pc_i = 64'h700;
    tick();
    bus.icache_gnt_i = 1'b0; bus.flush_i = 1'b0;
    #1 chk("t6_addr", W'(bus.icache_addr_o), W'(64'h700));
    bus.icache_gnt_i = 1'b1;
    tick();
    bus.icache_gnt_i = 1'b0; bus.icache_rvld_i = 1'b1; bus.icache_line_i = la;
    tick();
    bus.icache_line_i = lc;
    tick();
    bus.icache_rvld_i = 1'b0;
    #1 chk("t6_vld", W'(bus.bundle_vld_o), W'(8'hFF));
    chk("t6_inst", bus.bundle_inst_o, lc);
    chk("t6_bpc", W'(bus.bundle_pc_o), W'(64'h700));
    tick();

    // table-driven fetch vectors
    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // randomized run against the reference model
    begin
      logic [63:0] m_pc;
      m_pc = 64'h0;
      for (int c = 0; c < 2500; c++) begin
        tick();
        bus.flush_i = (c == 0) || ($urandom_range(0, 15) == 0);
        case ($urandom_range(0, 3))
          0:       bus.redirect_pc_i = {$urandom, $urandom};
          1:       bus.redirect_pc_i = 64'($urandom_range(0, 4095));
          2:       bus.redirect_pc_i = 64'hFFFF_FFFF_FFFF_FFC0 + 64'($urandom_range(0, 63));
          default: bus.redirect_pc_i = 64'h2000 + 64'($urandom_range(0, 255));
        endcase
        bus.buf_full_i   = ($urandom_range(0, 2) == 0);
        bus.icache_gnt_i = bus.icache_req_o && ($urandom_range(0, 2) != 0);
        if (cq_due.size() > 0 && cq_due[0] <= c) begin
          bus.icache_rvld_i = 1'b1;
          bus.icache_line_i = cq_data.pop_front();
          void'(cq_due.pop_front());
        end else begin
          bus.icache_rvld_i = 1'b0;
          bus.icache_line_i = rand_line();
        end
        #1;
        live_out = 1'b0;
        foreach (out_stale[i]) if (!out_stale[i]) live_out = 1'b1;
        exp_req  = !live_out && (exp_q.size() == 0);
        chk("rnd_req", W'(bus.icache_req_o), W'(exp_req));
        if (exp_req && c > 0)
          chk("rnd_addr", W'(bus.icache_addr_o), W'(m_pc - (m_pc % 64'd32)));
        emitting = (exp_q.size() > 0) && !bus.buf_full_i && !bus.flush_i;
        exp_vld  = emitting ? exp_q[0].mask : 8'h00;
        chk("rnd_vld", W'(bus.bundle_vld_o), W'(exp_vld));
        if (emitting) begin
          chk("rnd_inst", bus.bundle_inst_o, exp_q[0].inst);
          chk("rnd_bpc", W'(bus.bundle_pc_o), W'(exp_q[0].pc));
          m_pc = exp_q[0].next_pc;
          void'(exp_q.pop_front());
        end
        if (bus.icache_rvld_i) begin
          stale = (out_stale.size() > 0) ? out_stale.pop_front() : 1'b1;
          if (!stale) exp_q.push_back(model_bundle(m_pc, bus.icache_line_i));
        end
        if (bus.icache_gnt_i) begin
          out_stale.push_back(1'b0);
          cq_data.push_back(rand_line());
          cq_due.push_back(c + $urandom_range(1, 4));
        end
        if (bus.flush_i) begin
          foreach (out_stale[i]) out_stale[i] = 1'b1;
          exp_q.delete();
          m_pc = bus.redirect_pc_i & ~64'h3;
        end
      end
    end

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
